// File: rtl/capp_pkg.sv
// Shared CAPP definitions: array geometry, tag opcodes and tag FSM states.
// The tag controller's optional counter is enabled by TAG_CTRL_RESP_COUNT_EN.
package capp_pkg;

    localparam int NUM_CELLS = 100;
    localparam int WORD_W    = 32;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_SET_ALL      = 3'd1,
        OP_CLEAR_ALL    = 3'd2,
        OP_LOAD_MATCH   = 3'd3,
        OP_AND_MATCH    = 3'd4,
        OP_SELECT_FIRST = 3'd5,
        OP_STEP         = 3'd6,
        OP_ENUMERATE    = 3'd7
    } tag_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ENUM = 1'b1
    } tag_state_e;

endpackage

// File: rtl/first_responder.sv
// Lowest-index one-hot select over the tag vector.
// Two's-complement isolate of the lowest set bit; zero input gives zero.
module first_responder #(
    parameter int NUM_CELLS = capp_pkg::NUM_CELLS
) (
    input  logic [NUM_CELLS-1:0] vec,
    output logic [NUM_CELLS-1:0] onehot
);

    assign onehot = vec & (~vec + NUM_CELLS'(1));

endmodule

// File: rtl/tag_controller.sv
// Tag register and multiple-response resolver for the CAPP cell array.
// Define TAG_CTRL_RESP_COUNT_EN to build the registered responder counter.
module tag_controller #(
    parameter int NUM_CELLS = capp_pkg::NUM_CELLS,
    parameter int CNT_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_CELLS-1:0] match_lines,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    output logic [NUM_CELLS-1:0] tags,
    output logic                 some,
    output logic                 none,
    output logic                 enum_valid,
    input  logic                 enum_ready,
    output logic                 enum_done,
    output logic [CNT_W-1:0]     resp_count
);

    import capp_pkg::*;

    tag_state_e           state_q, state_d;
    logic [NUM_CELLS-1:0] tag_q, tag_d;
    logic [NUM_CELLS-1:0] work_q, work_d;
    logic [NUM_CELLS-1:0] tag_first, work_first;
    tag_op_e              op;
    logic                 cmd_fire;
    logic                 work_empty;

    assign op         = tag_op_e'(cmd_op);
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign work_empty = (work_q == '0);

    first_responder #(.NUM_CELLS(NUM_CELLS)) u_first_tag (
        .vec    (tag_q),
        .onehot (tag_first)
    );

    first_responder #(.NUM_CELLS(NUM_CELLS)) u_first_work (
        .vec    (work_q),
        .onehot (work_first)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire && op == OP_ENUMERATE) begin
                    state_d = ST_ENUM;
                end
            end
            ST_ENUM: begin
                if (work_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset gating keeps the handshake outputs quiet while RST is high.
    always_comb begin
        cmd_ready  = 1'b0;
        tags       = tag_q;
        enum_valid = 1'b0;
        enum_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = ~RST;
                tags      = tag_q;
            end
            ST_ENUM: begin
                tags       = work_first;
                enum_valid = ~work_empty & ~RST;
                enum_done  = work_empty & ~RST;
            end
            default: ;
        endcase
    end

    always_comb begin
        tag_d  = tag_q;
        work_d = work_q;
        if (cmd_fire) begin
            unique case (op)
                OP_NOP:          tag_d = tag_q;
                OP_SET_ALL:      tag_d = '1;
                OP_CLEAR_ALL:    tag_d = '0;
                OP_LOAD_MATCH:   tag_d = ~match_lines;
                OP_AND_MATCH:    tag_d = tag_q & ~match_lines;
                OP_SELECT_FIRST: tag_d = tag_first;
                OP_STEP:         tag_d = tag_q & ~tag_first;
                OP_ENUMERATE:    work_d = tag_q;
                default:         tag_d = tag_q;
            endcase
        end
        if (enum_valid && enum_ready) begin
            work_d = work_q & ~work_first;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_q  <= '0;
            work_q <= '0;
        end else begin
            tag_q  <= tag_d;
            work_q <= work_d;
        end
    end

    assign some = |tag_q;
    assign none = ~some;

`ifdef TAG_CTRL_RESP_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            cnt_d = cnt_d + CNT_W'(tag_q[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign resp_count = cnt_q;
`else
    assign resp_count = '0;
`endif

endmodule

// File: tb/tb_tag_controller.sv
// Self-checking bench for tag_controller: scoreboard of expected tags per cycle.
// Optional counter checks follow TAG_CTRL_RESP_COUNT_EN.
module tb_tag_controller;

    localparam int N = 100;
    localparam int CW = $clog2(N + 1);

    logic          CLK = 1'b0;
    logic          RST;
    logic [N-1:0]  match_lines;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N-1:0]  tags;
    logic          some;
    logic          none;
    logic          enum_valid;
    logic          enum_ready;
    logic          enum_done;
    logic [CW-1:0] resp_count;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] mdl_tag;

    tag_controller #(.NUM_CELLS(N)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .match_lines (match_lines),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .tags        (tags),
        .some        (some),
        .none        (none),
        .enum_valid  (enum_valid),
        .enum_ready  (enum_ready),
        .enum_done   (enum_done),
        .resp_count  (resp_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_tags(input string tag);
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(1), 128'(0));
        end else begin
            e = exp_q.pop_front();
            check(tag, 128'(tags), 128'(e));
        end
    endtask

    function automatic logic [N-1:0] first_of(input logic [N-1:0] x);
        logic [N-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) r = '0;
            if (x[i]) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
        logic [N-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    // Issue one IDLE command; model result is pushed, then compared after the edge.
    task automatic do_cmd(input logic [2:0] op, input logic [N-1:0] ml,
                          input string tag);
        @(negedge CLK);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        match_lines = ml;
        check({tag, "_ready"}, 128'(cmd_ready), 128'(1));
        case (op)
            3'd1: mdl_tag = '1;
            3'd2: mdl_tag = '0;
            3'd3: mdl_tag = ~ml;
            3'd4: mdl_tag = mdl_tag & ~ml;
            3'd5: mdl_tag = first_of(mdl_tag);
            3'd6: mdl_tag = mdl_tag & ~first_of(mdl_tag);
            default: ;
        endcase
        exp_q.push_back(mdl_tag);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        pop_tags(tag);
        check({tag, "_none"}, 128'(none), 128'(mdl_tag == '0));
        check({tag, "_some"}, 128'(some), 128'(mdl_tag != '0));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [N-1:0] ml3;
        RST         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        match_lines = '1;
        enum_ready  = 1'b0;
        mdl_tag     = '0;

        tick();
        tick();
        check("rst_tags", 128'(tags), 128'(0));
        check("rst_none", 128'(none), 128'(1));
        check("rst_some", 128'(some), 128'(0));
        check("rst_ready", 128'(cmd_ready), 128'(0));
        check("rst_ev", 128'(enum_valid), 128'(0));
        check("rst_ed", 128'(enum_done), 128'(0));
        check("rst_cnt", 128'(resp_count), 128'(0));
        @(negedge CLK);
        RST = 1'b0;

        do_cmd(3'd1, '1, "set_all");
        check("set_all_lit", 128'(tags), {28'h0, {N{1'b1}}});
        tick();
`ifdef TAG_CTRL_RESP_COUNT_EN
        check("cnt_set_all", 128'(resp_count), 128'(100));
`else
        check("cnt_off", 128'(resp_count), 128'(0));
`endif
        do_cmd(3'd2, '1, "clear_all");
        do_cmd(3'd0, '1, "nop");

        ml3 = ~bits3(5, 17, 42);
        do_cmd(3'd3, ml3, "load3");
        check("load3_lit", 128'(tags), 128'(bits3(5, 17, 42)));
        do_cmd(3'd4, ~bits3(17, -1, -1), "and17");
        check("and17_lit", 128'(tags), 128'(bits3(17, -1, -1)));

        do_cmd(3'd3, ml3, "reload_a");
        do_cmd(3'd5, '1, "sel_first");
        check("sel_first_lit", 128'(tags), 128'(bits3(5, -1, -1)));
        do_cmd(3'd3, ml3, "reload_b");
        do_cmd(3'd6, '1, "step1");
        check("step1_lit", 128'(tags), 128'(bits3(17, 42, -1)));
        do_cmd(3'd6, '1, "step2");
        check("step2_lit", 128'(tags), 128'(bits3(42, -1, -1)));
        do_cmd(3'd6, '1, "step3");
        check("step3_none", 128'(none), 128'(1));

        // Enumerate {3,99} with a stalled consumer and a spurious command.
        do_cmd(3'd3, ~bits3(3, 99, -1), "load_3_99");
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        tick();
        cmd_op = 3'd2;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(bits3(3, -1, -1));
            pop_tags("enum_hold");
            check("enum_hold_ev", 128'(enum_valid), 128'(1));
            check("enum_hold_rdy", 128'(cmd_ready), 128'(0));
            check("enum_hold_some", 128'(some), 128'(1));
            tick();
        end
        @(negedge CLK);
        enum_ready = 1'b1;
        exp_q.push_back(bits3(99, -1, -1));
        tick();
        pop_tags("enum_99");
        check("enum_99_ev", 128'(enum_valid), 128'(1));
        exp_q.push_back('0);
        tick();
        pop_tags("enum_end");
        check("enum_done_hi", 128'(enum_done), 128'(1));
        check("enum_end_ev", 128'(enum_valid), 128'(0));
        @(negedge CLK);
        enum_ready = 1'b0;
        cmd_valid  = 1'b0;
        exp_q.push_back(bits3(3, 99, -1));
        tick();
        pop_tags("enum_back");
        check("enum_done_lo", 128'(enum_done), 128'(0));
        check("enum_back_rdy", 128'(cmd_ready), 128'(1));

        // Enumerate on an empty tag register.
        do_cmd(3'd2, '1, "clr_e");
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        tick();
        cmd_valid = 1'b0;
        check("empty_done", 128'(enum_done), 128'(1));
        check("empty_ev", 128'(enum_valid), 128'(0));
        check("empty_tags", 128'(tags), 128'(0));
        tick();
        check("empty_done_lo", 128'(enum_done), 128'(0));
        check("empty_ev_lo", 128'(enum_valid), 128'(0));
        check("empty_idle", 128'(cmd_ready), 128'(1));

        // Reset in the middle of an enumeration.
        do_cmd(3'd3, ml3, "load_rst");
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        tick();
        cmd_valid = 1'b0;
        check("pre_rst_ev", 128'(enum_valid), 128'(1));
        @(negedge CLK);
        RST = 1'b1;
        tick();
        check("rst_mid_tags", 128'(tags), 128'(0));
        check("rst_mid_ed", 128'(enum_done), 128'(0));
        check("rst_mid_ev", 128'(enum_valid), 128'(0));
        @(negedge CLK);
        RST = 1'b0;
        mdl_tag = '0;
        #1;
        check("rst_mid_idle", 128'(cmd_ready), 128'(1));
        check("rst_mid_none", 128'(none), 128'(1));
        check("rst_mid_ed2", 128'(enum_done), 128'(0));
        do_cmd(3'd1, '1, "post_rst_set");
        check("sb_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
